// File: rtl/uart_pkg.sv
// uart_pkg: receive FSM state encodings, frame indicator values and oversample reload constants.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;
   localparam logic [1:0] FRAME_IDLE = 2'b00;
   localparam logic [1:0] FRAME_01   = 2'b01;
   localparam logic [1:0] FRAME_10   = 2'b10;
   localparam logic [3:0] HALF = 4'd7;
   localparam logic [3:0] FULL = 4'd15;
endpackage

// File: rtl/meta_harden.sv
// meta_harden: 2-FF synchronizer with asynchronous active-high reset to RST_VAL.
module meta_harden #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic sig_o
);
   logic meta_q, sync_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= sig_i;
         sync_q <= meta_q;
      end
   end
   assign sig_o = sync_q;
endmodule

// File: rtl/uart_rx_ctl.sv
// uart_rx_ctl: 16x-oversampled 8-bit UART receiver, LSbit first.
// Define UART_RX_PARITY_EN for an 11-bit frame with even parity checking.
module uart_rx_ctl
   import uart_pkg::*;
(
   input  logic       clk_rx,
   input  logic       rst_clk_rx,
   input  logic       baud_x16_en,
   input  logic       rxd_i,
   output logic [7:0] rx_data,
   output logic       rx_data_rdy,
   output logic       frm_err,
   output logic       parity_err,
   output logic       rx_store_qual,
   output logic [1:0] rx_frame_indicator,
   output logic       rx_bit_indicator
);
   logic       rxd_s;
   rx_state_e  state_q;
   logic [3:0] over_sample_cnt_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q, rx_data_q;
   logic       armed_q, rdy_q, frm_err_q;
   logic [1:0] frame_q, frame_old_q, frame_d;
   logic       at_sample;
`ifdef UART_RX_PARITY_EN
   logic       par_mis_q, par_err_q;
`endif

   meta_harden #(.RST_VAL(1'b1)) u_meta (
      .clk_i (clk_rx),
      .rst_i (rst_clk_rx),
      .sig_i (rxd_i),
      .sig_o (rxd_s)
   );

   assign at_sample = over_sample_cnt_q == 4'd0;
   assign frame_d   = (frame_old_q == FRAME_01) ? FRAME_10 : FRAME_01;

   always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
      if (rst_clk_rx) begin
         state_q           <= IDLE;
         over_sample_cnt_q <= 4'd0;
         bit_cnt_q         <= 3'd0;
         shift_q           <= 8'h00;
         rx_data_q         <= 8'h00;
         armed_q           <= 1'b1;
         rdy_q             <= 1'b0;
         frm_err_q         <= 1'b0;
         frame_q           <= FRAME_IDLE;
         frame_old_q       <= FRAME_10;
`ifdef UART_RX_PARITY_EN
         par_mis_q         <= 1'b0;
         par_err_q         <= 1'b0;
`endif
      end else begin
         rdy_q     <= 1'b0;
         frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
         if (baud_x16_en) begin
            if (!at_sample) over_sample_cnt_q <= over_sample_cnt_q - 4'd1;
            case (state_q)
               IDLE: begin
                  if (rxd_s) armed_q <= 1'b1;
                  else if (armed_q) begin
                     state_q           <= START;
                     over_sample_cnt_q <= HALF;
                     frame_q           <= frame_d;
                     frame_old_q       <= frame_d;
                  end
               end
               START: if (at_sample) begin
                  if (!rxd_s) begin
                     state_q           <= DATA;
                     over_sample_cnt_q <= FULL;
                     bit_cnt_q         <= 3'd0;
                  end else begin
                     state_q <= IDLE;
                     frame_q <= FRAME_IDLE;
                  end
               end
               DATA: if (at_sample) begin
                  shift_q[bit_cnt_q] <= rxd_s;
                  over_sample_cnt_q  <= FULL;
                  bit_cnt_q          <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
`else
                  if (bit_cnt_q == 3'd7) state_q <= STOP;
`endif
               end
`ifdef UART_RX_PARITY_EN
               PARITY: if (at_sample) begin
                  par_mis_q         <= rxd_s != ^shift_q;
                  over_sample_cnt_q <= FULL;
                  state_q           <= STOP;
               end
`endif
               STOP: if (at_sample) begin
                  state_q <= IDLE;
                  frame_q <= FRAME_IDLE;
                  // a low stop bit disarms so a break cannot retrigger until the line idles high
                  if (!rxd_s) begin
                     frm_err_q <= 1'b1;
                     armed_q   <= 1'b0;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (par_mis_q) par_err_q <= 1'b1;
`endif
                  else begin
                     rx_data_q <= shift_q;
                     rdy_q     <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_data            = rx_data_q;
   assign rx_data_rdy        = rdy_q;
   assign frm_err            = frm_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err         = par_err_q;
`else
   assign parity_err         = 1'b0;
`endif
   assign rx_frame_indicator = frame_q;
   assign rx_store_qual      = frame_q != FRAME_IDLE;
   assign rx_bit_indicator   = state_q != IDLE && at_sample;
endmodule

// File: tb/tb_uart_rx_ctl.sv
// tb_uart_rx_ctl: directed bench for uart_rx_ctl; define UART_RX_PARITY_EN to also exercise parity.
module tb_uart_rx_ctl;
   logic       clk_rx = 1'b0;
   logic       rst_clk_rx = 1'b1;
   logic       rxd_i = 1'b1;
   logic [1:0] div = 2'd0;
   logic       baud_x16_en;
   logic [7:0] rx_data;
   logic       rx_data_rdy, frm_err, parity_err, rx_store_qual, rx_bit_indicator;
   logic [1:0] rx_frame_indicator;
   int en_cnt = 0;
   int n_cmp = 0, n_err = 0;
   int rdy_n = 0, frm_n = 0, par_n = 0, rdy_at = 0, frm_at = 0;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_LEN = 176;
   logic bad_par = 1'b0;
`else
   localparam int FRAME_LEN = 160;
`endif
   localparam int STOP_AT = FRAME_LEN - 7;

   uart_rx_ctl dut (
      .clk_rx             (clk_rx),
      .rst_clk_rx         (rst_clk_rx),
      .baud_x16_en        (baud_x16_en),
      .rxd_i              (rxd_i),
      .rx_data            (rx_data),
      .rx_data_rdy        (rx_data_rdy),
      .frm_err            (frm_err),
      .parity_err         (parity_err),
      .rx_store_qual      (rx_store_qual),
      .rx_frame_indicator (rx_frame_indicator),
      .rx_bit_indicator   (rx_bit_indicator)
   );

   always #5 clk_rx = ~clk_rx;
   assign baud_x16_en = div == 2'd3;
   always @(posedge clk_rx) begin
      div <= div + 2'd1;
      if (baud_x16_en) en_cnt <= en_cnt + 1;
   end

   always @(negedge clk_rx) begin
      if (rx_data_rdy) begin
         rdy_n++;
         rdy_at = en_cnt;
      end
      if (frm_err) begin
         frm_n++;
         frm_at = en_cnt;
      end
      if (parity_err) par_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_en(input int n);
      int t = en_cnt + n;
      while (en_cnt < t) @(negedge clk_rx);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, output int start_at, output logic [1:0] ind);
      start_at = en_cnt;
      rxd_i = 1'b0;
      wait_en(8);
      chk("bit_ind_start", rx_bit_indicator, 1);
      chk("qual_mid", rx_store_qual, 1);
      ind = rx_frame_indicator;
      wait_en(1);
      chk("bit_ind_off", rx_bit_indicator, 0);
      wait_en(7);
      for (int i = 0; i < 8; i++) begin
         rxd_i = d[i];
         wait_en(16);
      end
`ifdef UART_RX_PARITY_EN
      rxd_i = ^d ^ bad_par;
      wait_en(16);
`endif
      rxd_i = stop;
      wait_en(16);
      rxd_i = 1'b1;
   endtask

   initial begin
      int s1, s2, r1, b, f, p;
      logic [1:0] i1, i2;
      repeat (3) @(negedge clk_rx);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_rdy", rx_data_rdy, 0);
      chk("rst_frm", frm_err, 0);
      chk("rst_par", parity_err, 0);
      chk("rst_ind", rx_frame_indicator, 0);
      chk("rst_qual", rx_store_qual, 0);
      chk("rst_bit_ind", rx_bit_indicator, 0);
      rst_clk_rx = 1'b0;
      wait_en(4);
      // normal frame
      b = rdy_n; f = frm_n;
      send_frame(8'hA5, 1'b1, s1, i1);
      chk("t1_data", rx_data, 8'hA5);
      chk("t1_rdy_cnt", rdy_n - b, 1);
      chk("t1_rdy_at", rdy_at - s1, STOP_AT);
      chk("t1_frm", frm_n - f, 0);
      chk("t1_ind", i1, 2'b01);
      chk("t1_ind_end", rx_frame_indicator, 2'b00);
      chk("t1_qual_end", rx_store_qual, 0);
      // false start
      b = rdy_n; f = frm_n;
      rxd_i = 1'b0;
      wait_en(2);
      chk("t2_ind_mid", rx_frame_indicator, 2'b10);
      wait_en(2);
      rxd_i = 1'b1;
      wait_en(20);
      chk("t2_ind_end", rx_frame_indicator, 2'b00);
      chk("t2_rdy", rdy_n - b, 0);
      chk("t2_frm", frm_n - f, 0);
      chk("t2_data", rx_data, 8'hA5);
      // framing error followed by a held-low line
      b = rdy_n; f = frm_n;
      send_frame(8'h3C, 1'b0, s1, i1);
      rxd_i = 1'b0;
      wait_en(40);
      chk("t3_ind", i1, 2'b01);
      chk("t3_frm_cnt", frm_n - f, 1);
      chk("t3_frm_at", frm_at - s1, STOP_AT);
      chk("t3_rdy", rdy_n - b, 0);
      chk("t3_data", rx_data, 8'hA5);
      chk("t3_no_retrig", rx_frame_indicator, 2'b00);
      rxd_i = 1'b1;
      wait_en(10);
      send_frame(8'h5A, 1'b1, s1, i1);
      chk("t3_resume_data", rx_data, 8'h5A);
      chk("t3_resume_ind", i1, 2'b10);
      // back-to-back from a fresh reset
      rst_clk_rx = 1'b1;
      repeat (2) @(negedge clk_rx);
      rst_clk_rx = 1'b0;
      wait_en(4);
      b = rdy_n;
      send_frame(8'h00, 1'b1, s1, i1);
      r1 = rdy_at;
      send_frame(8'hFF, 1'b1, s2, i2);
      chk("t4_ind1", i1, 2'b01);
      chk("t4_ind2", i2, 2'b10);
      chk("t4_gap", rdy_at - r1, FRAME_LEN);
      chk("t4_rdy_cnt", rdy_n - b, 2);
      chk("t4_data", rx_data, 8'hFF);
      // reset in the middle of 0x55
      b = rdy_n; f = frm_n;
      rxd_i = 1'b0;
      wait_en(16);
      for (int i = 0; i < 3; i++) begin
         rxd_i = i[0] ? 1'b0 : 1'b1;
         wait_en(16);
      end
      rxd_i = 1'b0;
      wait_en(8);
      rst_clk_rx = 1'b1;
      #1;
      chk("t5_rst_data", rx_data, 8'h00);
      chk("t5_rst_ind", rx_frame_indicator, 2'b00);
      chk("t5_rst_qual", rx_store_qual, 0);
      chk("t5_rst_bit_ind", rx_bit_indicator, 0);
      rxd_i = 1'b1;
      repeat (2) @(negedge clk_rx);
      rst_clk_rx = 1'b0;
      wait_en(4);
      send_frame(8'h81, 1'b1, s1, i1);
      chk("t5_data", rx_data, 8'h81);
      chk("t5_rdy_cnt", rdy_n - b, 1);
      chk("t5_frm", frm_n - f, 0);
      chk("t5_ind", i1, 2'b01);
`ifdef UART_RX_PARITY_EN
      b = rdy_n; p = par_n;
      bad_par = 1'b0;
      send_frame(8'h07, 1'b1, s1, i1);
      chk("t6_good_rdy", rdy_n - b, 1);
      chk("t6_good_par", par_n - p, 0);
      chk("t6_good_data", rx_data, 8'h07);
      b = rdy_n; p = par_n;
      bad_par = 1'b1;
      send_frame(8'h07, 1'b1, s1, i1);
      chk("t6_bad_rdy", rdy_n - b, 0);
      chk("t6_bad_par", par_n - p, 1);
      bad_par = 1'b0;
`else
      p = par_n;
      wait_en(4);
      chk("t6_par_tied", par_n - p + {31'd0, parity_err}, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
